// File: rtl/fp_cvt32to64_seq_pkg.sv
// Shared FP32/FP64 types, bias constants and operand classification for the
// single-to-double widening path.
package fp_cvt32to64_seq_pkg;

  localparam int FP32_BIAS = 127;
  localparam int FP64_BIAS = 1023;

  // Exponent offset applied to a normal FP32 exponent to land in FP64 range.
  localparam logic [10:0] EXP_REBIAS      = 11'(FP64_BIAS - FP32_BIAS);
  // Starting FP64 exponent for a subnormal before any normalising shift.
  localparam logic [10:0] EXP_SUBN32_BASE = 11'h381;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] sig;
  } fp32_t;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] sig;
  } fp64_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBN,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp32_class_e;

  function automatic fp32_class_e fp32_classify(input logic [7:0] exp, input logic [22:0] sig);
    fp32_class_e cls;
    if (exp == 8'h00) begin
      cls = (sig == 23'd0) ? CLS_ZERO : CLS_SUBN;
    end else if (exp == 8'hFF) begin
      if (sig == 23'd0) cls = CLS_INF;
      else              cls = sig[22] ? CLS_QNAN : CLS_SNAN;
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_cvt32to64_seq_cvt.sv
// Combinational FP32 -> FP64 widening by exponent rebias; correct for normal,
// infinity and NaN operands only (zero/subnormal are resolved by the caller).
module fp_cvt32to64_seq_cvt
  import fp_cvt32to64_seq_pkg::*;
(
  input  logic [31:0] a,
  output logic [63:0] y
);

  fp32_t       a_s;
  fp64_t       y_s;
  logic [51:0] frac;

  assign a_s = fp32_t'(a);

  generate
    for (genvar gi = 0; gi < 23; gi++) begin : g_frac
      assign frac[gi + 29] = a_s.sig[gi];
    end
  endgenerate
  assign frac[28:0] = '0;

  always_comb begin
    y_s.sign = a_s.sign;
    y_s.sig  = frac;
    if (a_s.exp == 8'hFF) y_s.exp = 11'h7FF;
    else                  y_s.exp = {3'b000, a_s.exp} + EXP_REBIAS;
  end

  assign y = 64'(y_s);

endmodule

// File: rtl/fp_cvt32to64_seq.sv
// Sequential FP32 -> FP64 front end: one-cycle path for normal/inf/NaN, serial
// one-bit-per-cycle normalisation for subnormals, registered handshaked result.
module fp_cvt32to64_seq
  import fp_cvt32to64_seq_pkg::*;
#(
  parameter bit QUIET_SNAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_v,
  output logic        i_rdy,
  input  logic [31:0] i,
  output logic        o_v,
  input  logic        o_rdy,
  output logic [63:0] o,
  output logic        o_snan,
  output logic        o_denorm
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

  state_e      state_reg, state_next;
  logic [23:0] m_reg, m_next;
  logic [10:0] e_reg, e_next;
  logic        sign_reg, sign_next;
  logic [63:0] o_reg, o_next;
  logic        o_v_reg, o_v_next;
  logic        snan_reg, snan_next;
  logic        denorm_reg, denorm_next;

  fp32_t       in_s;
  fp32_class_e in_cls;
  logic [63:0] cvt_o;
  logic        accept;
  logic [23:0] m_shift;
  logic [10:0] e_dec;
  fp64_t       norm_o;

  assign in_s   = fp32_t'(i);
  assign in_cls = fp32_classify(in_s.exp, in_s.sig);

  fp_cvt32to64_seq_cvt u_cvt (
    .a (i),
    .y (cvt_o)
  );

  assign i_rdy  = (state_reg == IDLE) || ((state_reg == DONE) && o_rdy);
  assign accept = i_v && i_rdy;

  assign m_shift = m_reg << 1;
  assign e_dec   = e_reg - 11'd1;

  always_comb begin
    norm_o.sign = sign_reg;
    norm_o.exp  = e_dec;
    norm_o.sig  = {m_shift[22:0], 29'd0};
  end

  always_comb begin
    state_next  = state_reg;
    m_next      = m_reg;
    e_next      = e_reg;
    sign_next   = sign_reg;
    o_next      = o_reg;
    o_v_next    = o_v_reg;
    snan_next   = snan_reg;
    denorm_next = denorm_reg;

    case (state_reg)
      NORM: begin
        m_next = m_shift;
        e_next = e_dec;
        if (m_shift[23]) begin
          o_next     = 64'(norm_o);
          o_v_next   = 1'b1;
          state_next = DONE;
        end
      end
      default: begin
        if (accept) begin
          snan_next   = 1'b0;
          denorm_next = 1'b0;
          o_v_next    = 1'b1;
          state_next  = DONE;
          case (in_cls)
            CLS_ZERO: o_next = {in_s.sign, 63'd0};
            CLS_SUBN: begin
              // Leading one is found by shifting until it reaches bit 23.
              m_next      = {1'b0, in_s.sig};
              e_next      = EXP_SUBN32_BASE;
              sign_next   = in_s.sign;
              o_next      = '0;
              denorm_next = 1'b1;
              o_v_next    = 1'b0;
              state_next  = NORM;
            end
            CLS_SNAN: begin
              o_next    = cvt_o;
              snan_next = 1'b1;
              if (QUIET_SNAN) o_next[51] = 1'b1;
            end
            default: o_next = cvt_o;
          endcase
        end else if ((state_reg == DONE) && o_rdy) begin
          o_v_next   = 1'b0;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      m_reg      <= '0;
      e_reg      <= '0;
      sign_reg   <= 1'b0;
      o_reg      <= '0;
      o_v_reg    <= 1'b0;
      snan_reg   <= 1'b0;
      denorm_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      m_reg      <= m_next;
      e_reg      <= e_next;
      sign_reg   <= sign_next;
      o_reg      <= o_next;
      o_v_reg    <= o_v_next;
      snan_reg   <= snan_next;
      denorm_reg <= denorm_next;
    end
  end

  assign o        = o_reg;
  assign o_v      = o_v_reg;
  assign o_snan   = snan_reg;
  assign o_denorm = denorm_reg;

endmodule

// File: tb/tb_fp_cvt32to64_seq.sv
// Directed bench for fp_cvt32to64_seq: hand-computed FP64 results, latency,
// hold behaviour, back-to-back acceptance and reset during normalisation.
module tb_fp_cvt32to64_seq;

  logic        clk;
  logic        rst_n;
  logic        i_v;
  logic        i_rdy;
  logic [31:0] i;
  logic        o_v;
  logic        o_rdy;
  logic [63:0] o;
  logic        o_snan;
  logic        o_denorm;

  int n_vec = 0;
  int n_err = 0;

  fp_cvt32to64_seq #(.QUIET_SNAN(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_v      (i_v),
    .i_rdy    (i_rdy),
    .i        (i),
    .o_v      (o_v),
    .o_rdy    (o_rdy),
    .o        (o),
    .o_snan   (o_snan),
    .o_denorm (o_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Single-cycle operand: result valid right after the accept edge, then drained.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [63:0] exp_o,
                         input logic exp_snan);
    i = a; i_v = 1'b1; o_rdy = 1'b1;
    step();
    i_v = 1'b0;
    chk({tag, ".o_v"}, 64'(o_v), 64'd1);
    chk({tag, ".o"}, o, exp_o);
    chk({tag, ".snan"}, 64'(o_snan), 64'(exp_snan));
    chk({tag, ".denorm"}, 64'(o_denorm), 64'd0);
    $display("vec %s: i=%h o=%h snan=%0b denorm=%0b", tag, a, o, o_snan, o_denorm);
    step();
    chk({tag, ".drain"}, 64'(o_v), 64'd0);
  endtask

  // Subnormal operand: count edges from accept to o_v; i changes are ignored.
  task automatic run_sub(input string tag, input logic [31:0] a, input logic [63:0] exp_o,
                         input int exp_k);
    int cnt;
    logic rdy_seen;
    i = a; i_v = 1'b1; o_rdy = 1'b1;
    step();
    i_v = 1'b0;
    i = 32'h3F80_0000;
    cnt = 0;
    rdy_seen = 1'b0;
    while (!o_v && cnt < 40) begin
      if (i_rdy) rdy_seen = 1'b1;
      step();
      cnt++;
    end
    chk({tag, ".k"}, 64'(cnt), 64'(exp_k));
    chk({tag, ".rdy_norm"}, 64'(rdy_seen), 64'd0);
    chk({tag, ".o"}, o, exp_o);
    chk({tag, ".denorm"}, 64'(o_denorm), 64'd1);
    $display("vec %s: i=%h o=%h k=%0d denorm=%0b", tag, a, o, cnt, o_denorm);
    step();
    chk({tag, ".drain"}, 64'(o_v), 64'd0);
  endtask

  initial begin
    int cnt;
    logic stale;

    rst_n = 1'b0; i_v = 1'b0; o_rdy = 1'b1; i = '0;
    step();
    step();
    chk("rst.o_v", 64'(o_v), 64'd0);
    chk("rst.o", o, 64'd0);
    chk("rst.flags", {62'd0, o_snan, o_denorm}, 64'd0);
    chk("rst.i_rdy", 64'(i_rdy), 64'd1);
    $display("vec reset: o_v=%0b o=%h i_rdy=%0b", o_v, o, i_rdy);
    rst_n = 1'b1;
    step();

    run_one("one",   32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0);
    run_one("nzero", 32'h8000_0000, 64'h8000_0000_0000_0000, 1'b0);
    run_one("snan",  32'h7F80_0001, 64'h7FF8_0000_2000_0000, 1'b1);
    run_one("qnan",  32'h7FC0_0000, 64'h7FF8_0000_0000_0000, 1'b0);
    run_one("pinf",  32'h7F80_0000, 64'h7FF0_0000_0000_0000, 1'b0);
    run_one("mpi",   32'hC049_0FDB, 64'hC009_21FB_6000_0000, 1'b0);

    run_sub("submin", 32'h0000_0001, 64'h36A0_0000_0000_0000, 23);
    run_sub("sub3",   32'h0000_0003, 64'h36B8_0000_0000_0000, 22);
    run_sub("nsubhi", 32'h8040_0000, 64'hB800_0000_0000_0000, 1);

    // Max subnormal with result held under backpressure.
    i = 32'h007F_FFFF; i_v = 1'b1; o_rdy = 1'b0;
    step();
    i_v = 1'b0;
    cnt = 0;
    while (!o_v && cnt < 40) begin
      step();
      cnt++;
    end
    chk("submax.k", 64'(cnt), 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk("submax.hold_v", 64'(o_v), 64'd1);
      chk("submax.hold_o", o, 64'h380F_FFFF_C000_0000);
      chk("submax.hold_dn", 64'(o_denorm), 64'd1);
      chk("submax.hold_rdy", 64'(i_rdy), 64'd0);
      step();
    end
    $display("vec submax: i=007fffff o=%h k=%0d held", o, cnt);
    o_rdy = 1'b1;
    step();
    chk("submax.drain", 64'(o_v), 64'd0);

    // Back-to-back acceptance without a bubble.
    i = 32'h4000_0000; i_v = 1'b1; o_rdy = 1'b1;
    step();
    chk("b2b.0.o_v", 64'(o_v), 64'd1);
    chk("b2b.0.o", o, 64'h4000_0000_0000_0000);
    chk("b2b.0.i_rdy", 64'(i_rdy), 64'd1);
    $display("vec b2b0: i=40000000 o=%h", o);
    i = 32'hFF80_0000;
    step();
    i_v = 1'b0;
    chk("b2b.1.o_v", 64'(o_v), 64'd1);
    chk("b2b.1.o", o, 64'hFFF0_0000_0000_0000);
    $display("vec b2b1: i=ff800000 o=%h", o);
    step();
    chk("b2b.drain", 64'(o_v), 64'd0);

    // Reset five cycles into normalisation discards the operation.
    i = 32'h0000_0001; i_v = 1'b1;
    step();
    i_v = 1'b0;
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstn.o_v", 64'(o_v), 64'd0);
    chk("rstn.o", o, 64'd0);
    chk("rstn.denorm", 64'(o_denorm), 64'd0);
    chk("rstn.i_rdy", 64'(i_rdy), 64'd1);
    stale = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (o_v) stale = 1'b1;
    end
    chk("rstn.stale", 64'(stale), 64'd0);
    $display("vec rst_norm: o_v=%0b o=%h stale=%0b", o_v, o, stale);

    run_one("after", 32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
